// File: rtl/renkon_linebuf.sv
// 5x5 sliding-window builder for a raster-scan square map: 4 circular line buffers plus a 5x5 register window.
// Optional RENKON_LINEBUF_OREG_EN adds an output register on window/window_valid (frame_done delayed to match).
module renkon_linebuf #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned LWIDTH = 10,
  parameter int unsigned FSIZE  = 5,
  parameter int unsigned MAXW   = 32
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic [LWIDTH-1:0]         w_img_size,
  input  logic                      start,
  input  logic                      in_en,
  input  logic [DWIDTH-1:0]         pixel_in,
  output logic [FSIZE*FSIZE*DWIDTH-1:0] window,
  output logic                      window_valid,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int unsigned AWIDTH = $clog2(MAXW);
  localparam int unsigned NLINE  = FSIZE - 1;
  localparam int unsigned VWIDTH = FSIZE * FSIZE * DWIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LWIDTH-1:0] size_q, col_q, row_q;
  logic              valid_q, done_q;
  logic              accept_c, col_wrap_c, last_c, pos_valid_c, fill_end_c;
  logic [AWIDTH-1:0] addr_c;

  logic [DWIDTH-1:0] lbuf     [NLINE][MAXW];
  logic [DWIDTH-1:0] win_q    [FSIZE][FSIZE];
  logic [DWIDTH-1:0] col_in_c [FSIZE];
  logic [VWIDTH-1:0] window_c;

  // start takes priority over a pixel offered in the same cycle
  assign accept_c    = in_en && !start && ((state_q == ST_FILL) || (state_q == ST_RUN));
  assign col_wrap_c  = (col_q == size_q - LWIDTH'(1));
  assign last_c      = col_wrap_c && (row_q == size_q - LWIDTH'(1));
  assign pos_valid_c = (row_q >= LWIDTH'(NLINE)) && (col_q >= LWIDTH'(NLINE));
  assign fill_end_c  = (row_q == LWIDTH'(NLINE)) && (col_q == LWIDTH'(NLINE));
  assign addr_c      = col_q[AWIDTH-1:0];

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Last-pixel check comes first so a minimum-size map can finish from FILL
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept_c && last_c) begin
            state_d = ST_DONE;
          end else if (accept_c && fill_end_c) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_c && last_c) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Counters, size register and registered status flags
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      size_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      busy    <= (state_d == ST_FILL) || (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
      valid_q <= accept_c && pos_valid_c;
      if (start) begin
        size_q <= w_img_size;
        col_q  <= '0;
        row_q  <= '0;
      end else if (accept_c) begin
        if (col_wrap_c) begin
          col_q <= '0;
          row_q <= row_q + LWIDTH'(1);
        end else begin
          col_q <= col_q + LWIDTH'(1);
        end
      end
    end
  end

  // New window column: oldest row from lbuf[0], newest row is the incoming pixel
  always_comb begin
    for (int r = 0; r < NLINE; r++) begin
      col_in_c[r] = lbuf[r][addr_c];
    end
    col_in_c[NLINE] = pixel_in;
  end

  // Line buffers hold no reset; every row advances one buffer at the current column
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int r = 0; r < NLINE - 1; r++) begin
        lbuf[r][addr_c] <= lbuf[r+1][addr_c];
      end
      lbuf[NLINE-1][addr_c] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int r = 0; r < FSIZE; r++) begin
        for (int c = 0; c < FSIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept_c) begin
      for (int r = 0; r < FSIZE; r++) begin
        for (int c = 0; c < FSIZE - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][FSIZE-1] <= col_in_c[r];
      end
    end
  end

  always_comb begin
    window_c = '0;
    for (int r = 0; r < FSIZE; r++) begin
      for (int c = 0; c < FSIZE; c++) begin
        window_c[(r*FSIZE+c)*DWIDTH +: DWIDTH] = win_q[r][c];
      end
    end
  end

`ifdef RENKON_LINEBUF_OREG_EN
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      window       <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window       <= window_c;
      window_valid <= valid_q;
      frame_done   <= done_q;
    end
  end
`else
  assign window       = window_c;
  assign window_valid = valid_q;
  assign frame_done   = done_q;
`endif

endmodule

// File: tb/tb_renkon_linebuf.sv
// Randomized bench for renkon_linebuf against a frame-level image model.
module tb_renkon_linebuf;

  localparam int unsigned DW   = 16;
  localparam int unsigned LW   = 10;
  localparam int unsigned NTAP = 25;
  localparam int unsigned VW   = NTAP * DW;
`ifdef RENKON_LINEBUF_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [VW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          xrst = 1'b0;
  logic          start = 1'b0;
  logic          in_en = 1'b0;
  logic [LW-1:0] w_img_size = '0;
  logic [DW-1:0] pixel_in = '0;
  vec_t          window;
  logic          window_valid, frame_done, busy;

  int n_tests = 0;
  int n_fail  = 0;

  renkon_linebuf dut (
    .clk(clk), .xrst(xrst), .w_img_size(w_img_size), .start(start),
    .in_en(in_en), .pixel_in(pixel_in), .window(window),
    .window_valid(window_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: store the frame as an image and derive each 5x5 window by coordinates
  int            cyc = 0;
  bit            m_active = 1'b0;
  int            m_w = 0;
  int            m_n = 0;
  int            m_r, m_c, m_slot;
  logic [DW-1:0] img [1024];
  bit            pend_v  [16];
  bit            pend_fd [16];
  vec_t          pend_win [16];
  vec_t          m_win;

  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      m_active = 1'b0;
      for (int i = 0; i < 16; i++) begin
        pend_v[i] = 1'b0;
        pend_fd[i] = 1'b0;
      end
    end else begin
      cyc++;
      m_slot = (cyc + LAT - 1) % 16;
      pend_v[m_slot]  = 1'b0;
      pend_fd[m_slot] = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_w = int'(w_img_size);
        m_n = 0;
      end else if (in_en && m_active) begin
        m_r = m_n / m_w;
        m_c = m_n % m_w;
        if (m_n < 1024) img[m_n] = pixel_in;
        if (m_r >= 4 && m_c >= 4) begin
          for (int k = 0; k < 25; k++)
            m_win[k*DW +: DW] = img[(m_r - 4 + k / 5) * m_w + (m_c - 4 + k % 5)];
          pend_v[m_slot]   = 1'b1;
          pend_win[m_slot] = m_win;
        end
        m_n++;
        if (m_n == m_w * m_w) begin
          m_active = 1'b0;
          pend_fd[m_slot] = 1'b1;
        end
      end
    end
  end

  int   n_valid = 0;
  int   n_done  = 0;
  int   c_slot;
  vec_t win_log [256];

  always @(negedge clk) begin
    if (xrst) begin
      c_slot = cyc % 16;
      check("window_valid", vec_t'(window_valid), vec_t'(pend_v[c_slot]));
      check("frame_done", vec_t'(frame_done), vec_t'(pend_fd[c_slot]));
      check("busy", vec_t'(busy), vec_t'(m_active));
      if (pend_v[c_slot]) check("window", window, pend_win[c_slot]);
      if (window_valid) begin
        win_log[n_valid % 256] = window;
        n_valid++;
      end
      if (frame_done) n_done++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int w, input bit with_pix);
    start = 1'b1;
    w_img_size = LW'(w);
    in_en = with_pix;
    pixel_in = DW'(16'h7fff);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_en = 1'b0;
  endtask

  // mode 0: 10*row+col, mode 1: raster index, mode 2: random
  task automatic feed(input int w, input int npix, input int unsigned pct, input int mode);
    int k = 0;
    while (k < npix) begin
      in_en = ($urandom_range(99) < pct);
      if (in_en) begin
        case (mode)
          0:       pixel_in = DW'(10 * (k / w) + k % w);
          1:       pixel_in = DW'(k);
          default: pixel_in = DW'($urandom);
        endcase
        k++;
      end else begin
        pixel_in = DW'($urandom);
      end
      @(posedge clk);
      #1;
    end
    in_en = 1'b0;
  endtask

  int   v0, d0, base3;
  vec_t tmp, exp_v;

  initial begin
    idle(3);
    check("rst_window", window, vec_t'(0));
    check("rst_valid", vec_t'(window_valid), vec_t'(0));
    check("rst_done", vec_t'(frame_done), vec_t'(0));
    check("rst_busy", vec_t'(busy), vec_t'(0));
    xrst = 1'b1;
    idle(2);

    // W=5 single window
    v0 = n_valid; d0 = n_done;
    do_start(5, 1'b0);
    feed(5, 25, 100, 1);
    idle(4);
    check("t2_nvalid", vec_t'(n_valid - v0), vec_t'(1));
    check("t2_ndone", vec_t'(n_done - d0), vec_t'(1));
    for (int k = 0; k < 25; k++) exp_v[k*DW +: DW] = DW'(k);
    check("t2_taps", win_log[v0 % 256], exp_v);

    // W=8 coordinate pattern, continuous
    v0 = n_valid; d0 = n_done; base3 = v0;
    do_start(8, 1'b0);
    feed(8, 64, 100, 0);
    idle(4);
    check("t3_nvalid", vec_t'(n_valid - v0), vec_t'(16));
    check("t3_ndone", vec_t'(n_done - d0), vec_t'(1));
    tmp = win_log[v0 % 256];
    check("t3_first_tap0", vec_t'(tmp[0 +: DW]), vec_t'(0));
    check("t3_first_tap24", vec_t'(tmp[24*DW +: DW]), vec_t'(44));
    tmp = win_log[(v0 + 15) % 256];
    check("t3_last_tap0", vec_t'(tmp[0 +: DW]), vec_t'(33));
    check("t3_last_tap24", vec_t'(tmp[24*DW +: DW]), vec_t'(77));

    // W=8 coordinate pattern with gaps
    v0 = n_valid; d0 = n_done;
    do_start(8, 1'b0);
    feed(8, 64, 50, 0);
    idle(4);
    check("t4_nvalid", vec_t'(n_valid - v0), vec_t'(16));
    check("t4_ndone", vec_t'(n_done - d0), vec_t'(1));
    for (int i = 0; i < 16; i++)
      check("t4_same_window", win_log[(v0 + i) % 256], win_log[(base3 + i) % 256]);

    // Reset mid-frame, then a clean frame
    do_start(8, 1'b0);
    feed(8, 40, 100, 2);
    xrst = 1'b0;
    #1;
    check("t1_rst_window", window, vec_t'(0));
    check("t1_rst_valid", vec_t'(window_valid), vec_t'(0));
    check("t1_rst_done", vec_t'(frame_done), vec_t'(0));
    check("t1_rst_busy", vec_t'(busy), vec_t'(0));
    @(posedge clk);
    #1;
    xrst = 1'b1;
    idle(2);
    v0 = n_valid; d0 = n_done;
    do_start(8, 1'b0);
    feed(8, 64, 70, 0);
    idle(4);
    check("t1_nvalid", vec_t'(n_valid - v0), vec_t'(16));
    for (int i = 0; i < 16; i++)
      check("t1_golden", win_log[(v0 + i) % 256], win_log[(base3 + i) % 256]);

    // Restart mid-frame (start collides with a pixel), then W=6
    v0 = n_valid; d0 = n_done;
    do_start(8, 1'b0);
    feed(8, 30, 100, 2);
    do_start(6, 1'b1);
    feed(6, 36, 80, 2);
    idle(4);
    check("t5_nvalid", vec_t'(n_valid - v0), vec_t'(4));
    check("t5_ndone", vec_t'(n_done - d0), vec_t'(1));

    // Random sizes and densities; in_en while idle must be ignored
    for (int f = 0; f < 6; f++) begin
      int w;
      w = int'($urandom_range(12, 5));
      v0 = n_valid; d0 = n_done;
      do_start(w, 1'b0);
      feed(w, w * w, $urandom_range(100, 30), 2);
      feed(w, 3, 100, 2);
      idle(3);
      check("rnd_nvalid", vec_t'(n_valid - v0), vec_t'((w - 4) * (w - 4)));
      check("rnd_ndone", vec_t'(n_done - d0), vec_t'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
